// File: rtl/commit_ctrl_pkg.sv
// Shared retirement types: commit FSM states, store size encoding and the
// bundled architectural-side write packet.
package sys_defs;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2,
    HALTED  = 2'd3
  } commit_state_t;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } mem_size_t;

  localparam int ZERO_REG     = 0;
  localparam int PKT_XLEN     = 32;
  localparam int PKT_REG_IDX_W = 5;

  // Grouped reg/mem outputs so a later integration can pass one bundle around.
  typedef struct packed {
    logic                     reg_wr_en;
    logic [PKT_REG_IDX_W-1:0] reg_wr_idx;
    logic [PKT_XLEN-1:0]      reg_wr_data;
    logic                     mem_req;
    logic [PKT_XLEN-1:0]      mem_addr;
    logic [PKT_XLEN-1:0]      mem_data;
    mem_size_t                mem_size;
  } COMMIT_CTRL_PACKET;

endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-head / architectural-side bundle of the commit controller. The master
// is the surrounding core (ROB head, memory), the slave is commit_ctrl.
interface commit_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 64
);
  logic                 head_valid;
  logic                 head_ready;
  logic                 head_is_store;
  logic                 head_mispredict;
  logic                 head_halt;
  logic [REG_IDX_W-1:0] head_dest_reg;
  logic [XLEN-1:0]      head_value;
  logic [XLEN-1:0]      head_addr;
  logic [1:0]           head_mem_size;
  logic [XLEN-1:0]      head_target_pc;
  logic                 rob_pop;
  logic                 reg_wr_en;
  logic [REG_IDX_W-1:0] reg_wr_idx;
  logic [XLEN-1:0]      reg_wr_data;
  logic                 mem_req;
  logic [XLEN-1:0]      mem_addr;
  logic [XLEN-1:0]      mem_data;
  logic [1:0]           mem_size;
  logic                 mem_ack;
  logic                 flush;
  logic [XLEN-1:0]      flush_pc;
  logic                 halted;
  logic [CNT_W-1:0]     retired_count;

  modport master (
    output head_valid, head_ready, head_is_store, head_mispredict, head_halt,
           head_dest_reg, head_value, head_addr, head_mem_size, head_target_pc,
           mem_ack,
    input  rob_pop, reg_wr_en, reg_wr_idx, reg_wr_data, mem_req, mem_addr,
           mem_data, mem_size, flush, flush_pc, halted, retired_count
  );

  modport slave (
    input  head_valid, head_ready, head_is_store, head_mispredict, head_halt,
           head_dest_reg, head_value, head_addr, head_mem_size, head_target_pc,
           mem_ack,
    output rob_pop, reg_wr_en, reg_wr_idx, reg_wr_data, mem_req, mem_addr,
           mem_data, mem_size, flush, flush_pc, halted, retired_count
  );
endinterface

// File: rtl/commit_ctrl.sv
// Retirement sequencer: pops the ROB head, writes the register file, walks
// stores through the memory handshake, flushes on mispredict, stops on halt.
module commit_ctrl
  import sys_defs::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 64
) (
  input  logic          clock,
  input  logic          reset,
  commit_ctrl_if.slave  bus
);

  commit_state_t        r_state;
  logic                 r_regWrEn;
  logic [REG_IDX_W-1:0] r_regWrIdx;
  logic [XLEN-1:0]      r_regWrData;
  logic                 r_memReq;
  logic [XLEN-1:0]      r_memAddr;
  logic [XLEN-1:0]      r_memData;
  logic [1:0]           r_memSize;
  logic                 r_flush;
  logic [XLEN-1:0]      r_flushPc;
  logic                 r_halted;
  logic [CNT_W-1:0]     r_retiredCount;

  logic w_retire;
  logic w_pop;

  // A store at the head does not pop until the memory has acknowledged it.
  assign w_retire = (r_state == RUN) && bus.head_valid && bus.head_ready;
  assign w_pop    = reset &&
                    ((w_retire && (bus.head_halt || !bus.head_is_store)) ||
                     ((r_state == ST_WAIT) && bus.mem_ack));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= RUN;
      r_regWrEn      <= 1'b0;
      r_regWrIdx     <= '0;
      r_regWrData    <= '0;
      r_memReq       <= 1'b0;
      r_memAddr      <= '0;
      r_memData      <= '0;
      r_memSize      <= '0;
      r_flush        <= 1'b0;
      r_flushPc      <= '0;
      r_halted       <= 1'b0;
      r_retiredCount <= '0;
    end else begin
      r_regWrEn <= 1'b0;
      r_flush   <= 1'b0;
      if (w_pop) begin
        r_retiredCount <= r_retiredCount + CNT_W'(1);
      end
      case (r_state)
        RUN: begin
          if (w_retire) begin
            if (bus.head_halt) begin
              r_halted <= 1'b1;
              r_state  <= HALTED;
            end else if (bus.head_is_store) begin
              r_memReq  <= 1'b1;
              r_memAddr <= bus.head_addr;
              r_memData <= bus.head_value;
              r_memSize <= bus.head_mem_size;
              r_state   <= ST_WAIT;
            end else begin
              if (bus.head_dest_reg != REG_IDX_W'(ZERO_REG)) begin
                r_regWrEn   <= 1'b1;
                r_regWrIdx  <= bus.head_dest_reg;
                r_regWrData <= bus.head_value;
              end
              if (bus.head_mispredict) begin
                r_flush   <= 1'b1;
                r_flushPc <= bus.head_target_pc;
                r_state   <= FLUSH;
              end
            end
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            r_memReq <= 1'b0;
            r_state  <= RUN;
          end
        end
        FLUSH:   r_state <= RUN;
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.rob_pop       = w_pop;
  assign bus.reg_wr_en     = r_regWrEn;
  assign bus.reg_wr_idx    = r_regWrIdx;
  assign bus.reg_wr_data   = r_regWrData;
  assign bus.mem_req       = r_memReq;
  assign bus.mem_addr      = r_memAddr;
  assign bus.mem_data      = r_memData;
  assign bus.mem_size      = r_memSize;
  assign bus.flush         = r_flush;
  assign bus.flush_pc      = r_flushPc;
  assign bus.halted        = r_halted;
  assign bus.retired_count = r_retiredCount;

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Retirement sequencer for the out-of-order core. Sits between the ROB head and the architectural side: register file write port, data memory write port and front-end redirect.
- Decides each cycle whether the ROB head may retire and pops it when it does.
- Sequences multi-cycle store commits with a memory request/ack handshake.
- Raises a one-cycle pipeline flush on a mispredicted branch and stops retiring permanently after a halt.

Parameters:
- XLEN, 32, data and address width.
- REG_IDX_W, 5, architectural register index width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- head_valid  in  1  ROB head entry is occupied
- head_ready  in  1  head result is complete
- head_is_store  in  1  head is a store
- head_mispredict  in  1  head is a resolved mispredicted branch
- head_halt  in  1  head is a halt instruction
- head_dest_reg  in  REG_IDX_W  destination register, ZERO_REG = none
- head_value  in  XLEN  result value or store data
- head_addr  in  XLEN  store address
- head_mem_size  in  2  store size (byte/half/word/double)
- head_target_pc  in  XLEN  corrected PC for a mispredict
- rob_pop  out  1  combinational; head retires this cycle
- reg_wr_en  out  1  registered register-file write enable
- reg_wr_idx  out  REG_IDX_W  registered write index
- reg_wr_data  out  XLEN  registered write data
- mem_req  out  1  registered store request
- mem_addr  out  XLEN  store address
- mem_data  out  XLEN  store data
- mem_size  out  2  store size
- mem_ack  in  1  memory accepted the store; meaningful only while mem_req=1
- flush  out  1  registered one-cycle pipeline flush
- flush_pc  out  XLEN  redirect PC, valid while flush=1
- halted  out  1  core halted
- retired_count  out  CNT_W  total number of retired instructions

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to RUN.
  - All registered outputs and retired_count go to 0.
  - rob_pop is 0 during any cycle in which reset=0.
  - Reset while in ST_WAIT drops mem_req on the next edge and does not pop the store.
- States: RUN, ST_WAIT, FLUSH, HALTED.
- Retire condition R = head_valid && head_ready, evaluated only in RUN. If R=0, nothing pops and the state is unchanged.
- When R=1, priority is halt > store > mispredict > normal:
  - Halt: rob_pop=1 in cycle N. halted=1 from N+1, state HALTED. HALTED is absorbing until reset; no further pops or writes.
  - Store:
    - rob_pop=0 in cycle N.
    - Latch head_addr, head_value and head_mem_size into mem_addr, mem_data and mem_size.
    - mem_req=1 from N+1; state ST_WAIT.
    - mem_req and the mem_* fields are held until mem_ack=1 is sampled.
    - In the ack cycle A: rob_pop=1 combinationally, mem_req=0 from A+1, state RUN.
    - The next head is evaluated at A+1 at the earliest.
    - No register write for a store.
  - Mispredict:
    - rob_pop=1 in cycle N.
    - At N+1: flush=1 and flush_pc=head_target_pc; register write per the normal rule (link register).
    - State FLUSH for exactly one cycle (N+1). The head is ignored during FLUSH, then state returns to RUN.
  - Normal: rob_pop=1 in cycle N.
- Register write rule, applied at cycle N+1 for every pop except a store or halt:
  - reg_wr_en = (head_dest_reg != ZERO_REG).
  - reg_wr_idx and reg_wr_data are captured from cycle N.
  - Otherwise reg_wr_en=0, and idx/data hold their previous values.
- At most one pop per cycle. flush, reg_wr_en and mem_req are single-purpose registers cleared whenever their condition is not met.
- retired_count increments by 1 on every clock edge where rob_pop=1, and wraps modulo 2^CNT_W.
- head_* inputs are don't-care when head_valid=0, and in ST_WAIT, FLUSH and HALTED.

Decomposition:
- Shared package (sys_defs) holds:
  - commit_state_t enum {RUN, ST_WAIT, FLUSH, HALTED}.
  - ZERO_REG.
  - MEM_SIZE encoding.
  - A COMMIT_CTRL_PACKET struct grouping the reg_wr_* and mem_* outputs for later integration.
- No sub-module; the counter is inline.

Test Plan:
- Reset=0 for 2 cycles with head_valid=1, head_ready=1 -> rob_pop=0 and all outputs 0. Release reset -> pop in the first RUN cycle.
- Normal ALU head: dest=5, value=0xDEADBEEF, ready -> rob_pop=1 in N; at N+1 reg_wr_en=1, idx=5, data=0xDEADBEEF; retired_count=1. Repeat with dest=ZERO_REG -> reg_wr_en=0, count=2.
- Store: addr=0x1000, data=0x55, size=WORD; ack held low 3 cycles -> mem_req=1 for cycles N+1..N+4 with ack=1 at N+4; rob_pop=1 only at N+4; mem_req=0 at N+5.
- Mispredict: dest=1, target=0x2040 -> pop at N; flush=1 and flush_pc=0x2040 only at N+1; reg write r1 at N+1; no pop at N+1 even though head_valid=1; pop resumes at N+2.
- Halt with a following valid head -> pop once; halted=1 from N+1; no further pops for 20 cycles; retired_count frozen.
- Reset asserted while in ST_WAIT -> mem_req=0 next cycle, no pop, state RUN; retired_count=0 after the reset edge.
